krnl_acc_cmd_sched: RTL and testbench
=====================================

Name: krnl_acc_cmd_sched

Overview:
- Sequences one kernel invocation between the AXI-Lite control slave and the AES/CBC datapath.
- On ap_start it latches the job configuration (mode, cbc_mode, src_addr, dest_addr, words_num).
- It splits the job into AXI4 read and write burst commands for the read/write master engines and tracks write completions.
- It drives the ap_ctrl_chain handshake (ap_ready, ap_idle, ap_done/ap_continue) back to the control slave.

Parameters:
- WORD_BYTES, 16, bytes per data word (one 128-bit AES block); address bits [3:0] are ignored.
- MAX_BURST, 16, maximum beats per burst command (power of two, 1..256).
- MAX_OUTSTANDING, 4, maximum write bursts issued but not yet acknowledged by wr_done (1..15).

Ports:
- ACLK  in  1  clock
- ARESETn  in  1  reset, asynchronous, active-low
- ap_start  in  1  start request from control slave (level, held until ap_ready)
- ap_continue  in  1  one-cycle pulse; acknowledges ap_done
- ap_ready  out  1  one-cycle pulse: configuration latched, ap_start may drop
- ap_idle  out  1  high when no job is active
- ap_done  out  1  job complete; held until ap_continue
- mode, cbc_mode  in  1 each  job options
- src_addr, dest_addr  in  64 each  byte addresses
- words_num  in  32  job length in 16-byte words
- cfg_mode, cfg_cbc_mode  out  1 each  latched options for the datapath
- rd_cmd_valid / rd_cmd_ready  out / in  1 / 1  read command handshake
- rd_cmd_addr  out  64  read burst byte address
- rd_cmd_len  out  8  read beats minus 1
- wr_cmd_valid / wr_cmd_ready  out / in  1 / 1  write command handshake
- wr_cmd_addr  out  64  write burst byte address
- wr_cmd_len  out  8  write beats minus 1
- wr_done  in  1  one-cycle pulse per completed write burst (B response)

Behaviour:
- Reset values (asynchronous, ARESETn low): state IDLE, ap_idle=1, ap_ready=0, ap_done=0, rd/wr_cmd_valid=0, all counters 0, cfg_* = 0.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - When ap_start=1, latch all config inputs, pulse ap_ready for exactly one cycle, and go to ISSUE the next cycle.
  - If words_num==0, go to DONE instead; no commands are issued.
- ISSUE:
  - The read and write generators run independently; each holds its own remaining-word count and current address.
  - Burst length = min(remaining, MAX_BURST, words left in the current 4 KB page = (4096 - addr[11:0]) / 16).
  - *_cmd_len = length - 1.
  - A command is held stable while valid && !ready.
  - On handshake: addr += length*16 and remaining -= length, both registered.
  - A read command may issue only when (rd_bursts_issued - wr_done_count) < MAX_OUTSTANDING. This bounds datapath buffering.
  - A write command may issue only when outstanding writes < MAX_OUTSTANDING.
  - Go to DRAIN when both remaining counts reach 0.
- DRAIN: wait until outstanding writes == 0, then go to DONE.
- DONE:
  - ap_done=1 and ap_idle=0.
  - On ap_continue=1: clear ap_done the next cycle and go to IDLE (ap_idle=1).
  - ap_start is ignored in DONE.
- ap_idle = (state==IDLE), registered.
- Simultaneous wr_done and wr_cmd handshake in one cycle: the outstanding count is unchanged.
- wr_done while outstanding==0 is ignored (count saturates at 0).
- 64-bit address increments wrap modulo 2^64; there is no carry error.
- ap_continue outside DONE is ignored.
- Reset asserted mid-job aborts immediately: all valids drop and state returns to IDLE.

Decomposition:
- Shared package krnl_acc_pkg holds:
  - FSM state encodings
  - PAGE_BYTES=4096
  - WORD_SHIFT=4
  - default MAX_BURST / MAX_OUTSTANDING
- Sub-module krnl_acc_burst_gen, instantiated twice (read and write):
  - Takes a start address and word count; produces addr/len/valid.
  - Consumes ready and an enable (the credit check).
  - Asserts a last_issued flag.

Test Plan:
- Basic: src=0x1000, dest=0x8000, words=40 -> reads (0x1000,15), (0x1100,15), (0x1200,7); writes mirror at 0x8000. ap_ready pulses once; ap_done rises after the 3rd wr_done.
- 4 KB crossing: src=0x1FC0, words=8 -> reads (0x1FC0,len 3), (0x2000,len 3).
- Zero length: words=0 -> ap_ready pulse, no commands, ap_done the next cycle; ap_continue returns ap_idle=1.
- Credit stall: words=160, MAX_OUTSTANDING=4, wr_done withheld -> exactly 4 write and 4 read commands issued, then both valids stay low. Releasing one wr_done allows exactly one more of each.
- Backpressure: rd_cmd_ready low for 10 cycles -> rd_cmd_addr/len stable and valid held. Then ap_start held high in DONE with no ap_continue -> no restart; ap_done stays 1.
- Reset mid-ISSUE after 2 bursts -> valids 0 and ap_idle 1 immediately. A new job with words=16 then runs cleanly from its fresh addresses.

Source files
------------

// File: rtl/krnl_acc_pkg.sv
// Shared definitions for the kernel accelerator command scheduler.
// Holds the FSM state encodings, the page/word geometry, the default burst
// and credit limits, and the payload struct for one burst command.
package krnl_acc_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int unsigned PAGE_BYTES          = 4096;
    localparam int unsigned WORD_SHIFT          = 4;
    localparam int unsigned DEF_MAX_BURST       = 16;
    localparam int unsigned DEF_MAX_OUTSTANDING = 4;

    localparam int unsigned ADDR_W  = 64;
    localparam int unsigned WORDS_W = 32;
    localparam int unsigned LEN_W   = 8;

    // One AXI4 burst command: byte address and beats-minus-one.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  len;
    } cmd_t;

endpackage

// File: rtl/krnl_acc_burst_gen.sv
// Burst command generator: splits a (start address, word count) job into
// AXI4 bursts that never exceed MAX_BURST beats or cross a 4 KB page.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   load                    latch start_addr/start_words for a new job
//   enable                  permission to raise a new command (credit + state)
//   ready                   command accepted by the master engine
//   valid, cmd              command handshake and payload (registered)
//   last_issued             every word of the job has been handed out
module krnl_acc_burst_gen
    import krnl_acc_pkg::*;
#(
    parameter int unsigned WORD_BYTES = 16,
    parameter int unsigned MAX_BURST  = DEF_MAX_BURST
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [ADDR_W-1:0]  start_addr,
    input  logic [WORDS_W-1:0] start_words,
    input  logic               enable,
    input  logic               ready,
    output logic               valid,
    output cmd_t               cmd,
    output logic               last_issued
);

    localparam int unsigned PAGE_WORDS = PAGE_BYTES >> WORD_SHIFT;
    localparam int unsigned PIDX_W     = $clog2(PAGE_WORDS);
    localparam int unsigned PW_W       = PIDX_W + 1;

    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [WORDS_W-1:0] rem_q, rem_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               valid_q, valid_d;
    logic               last_q, last_d;

    logic [PW_W-1:0]    page_words_c;
    logic [WORDS_W-1:0] burst_c;
    logic [PW_W-1:0]    beats_c;

    // Next burst size: min(remaining, MAX_BURST, words left in this page).
    always_comb begin
        page_words_c = PW_W'(PAGE_WORDS) - PW_W'(addr_q[WORD_SHIFT +: PIDX_W]);
        burst_c      = rem_q;
        if (burst_c > WORDS_W'(MAX_BURST)) begin
            burst_c = WORDS_W'(MAX_BURST);
        end
        if (burst_c > WORDS_W'(page_words_c)) begin
            burst_c = WORDS_W'(page_words_c);
        end
        beats_c = PW_W'(len_q) + PW_W'(1);
    end

    // Command valid drops for one cycle after each handshake so the credit
    // check always sees counters that already include the previous burst.
    always_comb begin
        addr_d  = addr_q;
        rem_d   = rem_q;
        len_d   = len_q;
        valid_d = valid_q;
        if (load) begin
            addr_d  = start_addr;
            rem_d   = start_words;
            valid_d = 1'b0;
        end else if (valid_q) begin
            if (ready) begin
                valid_d = 1'b0;
                addr_d  = addr_q + ADDR_W'(beats_c) * ADDR_W'(WORD_BYTES);
                rem_d   = rem_q - WORDS_W'(beats_c);
            end
        end else if (enable && (rem_q != '0)) begin
            valid_d = 1'b1;
            len_d   = LEN_W'(burst_c - WORDS_W'(1));
        end
        last_d = (rem_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            rem_q   <= '0;
            len_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            len_q   <= len_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        cmd         = '0;
        cmd.addr    = addr_q;
        cmd.len     = len_q;
        valid       = valid_q;
        last_issued = last_q;
    end

endmodule

// File: rtl/krnl_acc_cmd_sched.sv
// Kernel command scheduler: runs one invocation between the AXI-Lite
// control slave (ap_ctrl_chain) and the AES/CBC datapath.
// Ports:
//   ACLK, ARESETn                       clock, async active-low reset
//   ap_start/ap_ready/ap_idle/ap_done/ap_continue   control handshake
//   mode, cbc_mode, src_addr, dest_addr, words_num  job config (latched on start)
//   cfg_mode, cfg_cbc_mode              latched options for the datapath
//   rd_cmd_*, wr_cmd_*                  burst commands to the read/write masters
//   wr_done                             one pulse per completed write burst
module krnl_acc_cmd_sched
    import krnl_acc_pkg::*;
#(
    parameter int unsigned WORD_BYTES      = 16,
    parameter int unsigned MAX_BURST       = DEF_MAX_BURST,
    parameter int unsigned MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
    input  logic               ACLK,
    input  logic               ARESETn,
    input  logic               ap_start,
    input  logic               ap_continue,
    output logic               ap_ready,
    output logic               ap_idle,
    output logic               ap_done,
    input  logic               mode,
    input  logic               cbc_mode,
    input  logic [ADDR_W-1:0]  src_addr,
    input  logic [ADDR_W-1:0]  dest_addr,
    input  logic [WORDS_W-1:0] words_num,
    output logic               cfg_mode,
    output logic               cfg_cbc_mode,
    output logic               rd_cmd_valid,
    input  logic               rd_cmd_ready,
    output logic [ADDR_W-1:0]  rd_cmd_addr,
    output logic [LEN_W-1:0]   rd_cmd_len,
    output logic               wr_cmd_valid,
    input  logic               wr_cmd_ready,
    output logic [ADDR_W-1:0]  wr_cmd_addr,
    output logic [LEN_W-1:0]   wr_cmd_len,
    input  logic               wr_done
);

    localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [1:0]         state_q, state_d;
    logic               ap_ready_q, ap_ready_d;
    logic               ap_idle_q, ap_idle_d;
    logic               ap_done_q, ap_done_d;
    logic               cfg_mode_q, cfg_mode_d;
    logic               cfg_cbc_q, cfg_cbc_d;
    logic [OUT_W-1:0]   wr_out_q, wr_out_d;
    logic [WORDS_W-1:0] rd_issued_q, rd_issued_d;
    logic [WORDS_W-1:0] wr_acked_q, wr_acked_d;

    logic               start_c, rd_fire_c, wr_fire_c, done_ok_c;
    logic               rd_en_c, wr_en_c;
    logic signed [WORDS_W-1:0] rd_ahead_c;

    logic rd_valid, wr_valid, rd_last, wr_last;
    cmd_t rd_cmd, wr_cmd;

    krnl_acc_burst_gen #(
        .WORD_BYTES (WORD_BYTES),
        .MAX_BURST  (MAX_BURST)
    ) u_rd_gen (
        .clk         (ACLK),
        .rst_n       (ARESETn),
        .load        (start_c),
        .start_addr  (src_addr),
        .start_words (words_num),
        .enable      (rd_en_c),
        .ready       (rd_cmd_ready),
        .valid       (rd_valid),
        .cmd         (rd_cmd),
        .last_issued (rd_last)
    );

    krnl_acc_burst_gen #(
        .WORD_BYTES (WORD_BYTES),
        .MAX_BURST  (MAX_BURST)
    ) u_wr_gen (
        .clk         (ACLK),
        .rst_n       (ARESETn),
        .load        (start_c),
        .start_addr  (dest_addr),
        .start_words (words_num),
        .enable      (wr_en_c),
        .ready       (wr_cmd_ready),
        .valid       (wr_valid),
        .cmd         (wr_cmd),
        .last_issued (wr_last)
    );

    // Credit accounting. Reads may run ahead of write completions by at most
    // MAX_OUTSTANDING bursts; the difference is signed because writes can
    // complete before the matching reads have even been issued.
    always_comb begin
        start_c    = (state_q == ST_IDLE) && ap_start;
        rd_fire_c  = rd_valid && rd_cmd_ready;
        wr_fire_c  = wr_valid && wr_cmd_ready;
        done_ok_c  = wr_done && (wr_out_q != '0);
        rd_ahead_c = rd_issued_q - wr_acked_q;
        rd_en_c    = (state_q == ST_ISSUE) &&
                     (rd_ahead_c < $signed(WORDS_W'(MAX_OUTSTANDING)));
        wr_en_c    = (state_q == ST_ISSUE) &&
                     (wr_out_q < OUT_W'(MAX_OUTSTANDING));

        wr_out_d = wr_out_q;
        if (wr_fire_c && !done_ok_c) begin
            wr_out_d = wr_out_q + OUT_W'(1);
        end else if (!wr_fire_c && done_ok_c) begin
            wr_out_d = wr_out_q - OUT_W'(1);
        end

        if (start_c) begin
            rd_issued_d = '0;
            wr_acked_d  = '0;
        end else begin
            rd_issued_d = rd_issued_q + WORDS_W'(rd_fire_c);
            wr_acked_d  = wr_acked_q + WORDS_W'(done_ok_c);
        end
    end

    // Job sequencing FSM.
    always_comb begin
        state_d    = state_q;
        ap_ready_d = 1'b0;
        cfg_mode_d = cfg_mode_q;
        cfg_cbc_d  = cfg_cbc_q;
        case (state_q)
            ST_IDLE: begin
                if (ap_start) begin
                    ap_ready_d = 1'b1;
                    cfg_mode_d = mode;
                    cfg_cbc_d  = cbc_mode;
                    state_d    = (words_num == '0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (rd_last && wr_last) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (wr_out_q == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (ap_continue) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        ap_idle_d = (state_d == ST_IDLE);
        ap_done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q     <= ST_IDLE;
            ap_ready_q  <= 1'b0;
            ap_idle_q   <= 1'b1;
            ap_done_q   <= 1'b0;
            cfg_mode_q  <= 1'b0;
            cfg_cbc_q   <= 1'b0;
            wr_out_q    <= '0;
            rd_issued_q <= '0;
            wr_acked_q  <= '0;
        end else begin
            state_q     <= state_d;
            ap_ready_q  <= ap_ready_d;
            ap_idle_q   <= ap_idle_d;
            ap_done_q   <= ap_done_d;
            cfg_mode_q  <= cfg_mode_d;
            cfg_cbc_q   <= cfg_cbc_d;
            wr_out_q    <= wr_out_d;
            rd_issued_q <= rd_issued_d;
            wr_acked_q  <= wr_acked_d;
        end
    end

    always_comb begin
        ap_ready     = ap_ready_q;
        ap_idle      = ap_idle_q;
        ap_done      = ap_done_q;
        cfg_mode     = cfg_mode_q;
        cfg_cbc_mode = cfg_cbc_q;
        rd_cmd_valid = rd_valid;
        rd_cmd_addr  = rd_cmd.addr;
        rd_cmd_len   = rd_cmd.len;
        wr_cmd_valid = wr_valid;
        wr_cmd_addr  = wr_cmd.addr;
        wr_cmd_len   = wr_cmd.len;
    end

endmodule

// File: tb/tb_krnl_acc_cmd_sched.sv
// Self-checking bench for krnl_acc_cmd_sched: a job-level model predicts the
// full read/write burst lists and credit limits; directed jobs pin the model.
module tb_krnl_acc_cmd_sched;

    localparam int MB = 16;
    localparam int MO = 4;

    typedef struct packed {
        logic [63:0] addr;
        logic [7:0]  len;
    } bcmd_t;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic        ap_start, ap_continue, ap_ready, ap_idle, ap_done;
    logic        mode, cbc_mode, cfg_mode, cfg_cbc_mode;
    logic [63:0] src_addr, dest_addr, rd_cmd_addr, wr_cmd_addr;
    logic [31:0] words_num;
    logic        rd_cmd_valid, rd_cmd_ready, wr_cmd_valid, wr_cmd_ready, wr_done;
    logic [7:0]  rd_cmd_len, wr_cmd_len;

    krnl_acc_cmd_sched #(
        .WORD_BYTES      (16),
        .MAX_BURST       (MB),
        .MAX_OUTSTANDING (MO)
    ) dut (
        .ACLK         (ACLK),
        .ARESETn      (ARESETn),
        .ap_start     (ap_start),
        .ap_continue  (ap_continue),
        .ap_ready     (ap_ready),
        .ap_idle      (ap_idle),
        .ap_done      (ap_done),
        .mode         (mode),
        .cbc_mode     (cbc_mode),
        .src_addr     (src_addr),
        .dest_addr    (dest_addr),
        .words_num    (words_num),
        .cfg_mode     (cfg_mode),
        .cfg_cbc_mode (cfg_cbc_mode),
        .rd_cmd_valid (rd_cmd_valid),
        .rd_cmd_ready (rd_cmd_ready),
        .rd_cmd_addr  (rd_cmd_addr),
        .rd_cmd_len   (rd_cmd_len),
        .wr_cmd_valid (wr_cmd_valid),
        .wr_cmd_ready (wr_cmd_ready),
        .wr_cmd_addr  (wr_cmd_addr),
        .wr_cmd_len   (wr_cmd_len),
        .wr_done      (wr_done)
    );

    always #5 ACLK = ~ACLK;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Words in the next burst from the job-level rule.
    function automatic int burst_words(input logic [63:0] a, input longint rem);
        longint page_left;
        longint n;
        page_left = (64'd4096 - longint'(a[11:0])) / 16;
        n = rem;
        if (n > MB) n = MB;
        if (n > page_left) n = page_left;
        return int'(n);
    endfunction

    // ---------------- model / compare state (owned by compare process) -----
    bcmd_t exp_rd[$], exp_wr[$], rd_log[$], wr_log[$];
    int    rd_hs, wr_hs, done_seen, ready_cnt, b_req;
    logic  prev_done;
    logic  rd_stall_p, wr_stall_p;
    bcmd_t rd_p, wr_p;

    // responder state
    int    b_sent, b_grant;
    logic  auto_b;

    initial begin
        logic [63:0] a;
        longint      r;
        int          n;
        bcmd_t       e;
        ready_cnt = 0; b_req = 0; rd_hs = 0; wr_hs = 0; done_seen = 0;
        prev_done = 1'b0; rd_stall_p = 1'b0; wr_stall_p = 1'b0;
        rd_p = '0; wr_p = '0;
        forever begin
            @(negedge ACLK);
            if (ARESETn !== 1'b1) begin
                exp_rd.delete(); exp_wr.delete(); rd_log.delete(); wr_log.delete();
                rd_hs = 0; wr_hs = 0; done_seen = 0; b_req = 0;
                prev_done = 1'b0; rd_stall_p = 1'b0; wr_stall_p = 1'b0;
                continue;
            end
            if (ap_ready) begin
                ready_cnt++;
                chk("cfg_mode", 64'(cfg_mode), 64'(mode));
                chk("cfg_cbc_mode", 64'(cfg_cbc_mode), 64'(cbc_mode));
                exp_rd.delete(); exp_wr.delete(); rd_log.delete(); wr_log.delete();
                rd_hs = 0; wr_hs = 0; done_seen = 0;
                a = src_addr; r = longint'(words_num);
                while (r > 0) begin
                    n = burst_words(a, r);
                    exp_rd.push_back({a, 8'(n - 1)});
                    a = a + 64'(n) * 64'd16; r = r - n;
                end
                a = dest_addr; r = longint'(words_num);
                while (r > 0) begin
                    n = burst_words(a, r);
                    exp_wr.push_back({a, 8'(n - 1)});
                    a = a + 64'(n) * 64'd16; r = r - n;
                end
            end
            if (rd_stall_p) begin
                chk("rd_hold_valid", 64'(rd_cmd_valid), 64'd1);
                chk("rd_hold_cmd", {rd_cmd_addr[55:0], rd_cmd_len}, {rd_p.addr[55:0], rd_p.len});
            end
            if (wr_stall_p) begin
                chk("wr_hold_valid", 64'(wr_cmd_valid), 64'd1);
                chk("wr_hold_cmd", {wr_cmd_addr[55:0], wr_cmd_len}, {wr_p.addr[55:0], wr_p.len});
            end
            if (rd_cmd_valid && rd_cmd_ready) begin
                chk("rd_credit", 64'((rd_hs - done_seen) < MO), 64'd1);
                chk("rd_cmd_expected", 64'(exp_rd.size() != 0), 64'd1);
                if (exp_rd.size() != 0) begin
                    e = exp_rd.pop_front();
                    chk("rd_addr", rd_cmd_addr, e.addr);
                    chk("rd_len", 64'(rd_cmd_len), 64'(e.len));
                end
                rd_log.push_back({rd_cmd_addr, rd_cmd_len});
                rd_hs++;
            end
            if (wr_cmd_valid && wr_cmd_ready) begin
                chk("wr_credit", 64'((wr_hs - done_seen) < MO), 64'd1);
                chk("wr_cmd_expected", 64'(exp_wr.size() != 0), 64'd1);
                if (exp_wr.size() != 0) begin
                    e = exp_wr.pop_front();
                    chk("wr_addr", wr_cmd_addr, e.addr);
                    chk("wr_len", 64'(wr_cmd_len), 64'(e.len));
                end
                wr_log.push_back({wr_cmd_addr, wr_cmd_len});
                wr_hs++;
                b_req++;
            end
            if (ap_done && !prev_done) begin
                chk("done_rd_all_issued", 64'(exp_rd.size()), 64'd0);
                chk("done_wr_all_issued", 64'(exp_wr.size()), 64'd0);
                chk("done_all_acked", 64'(done_seen), 64'(wr_hs));
                chk("done_not_idle", 64'(ap_idle), 64'd0);
            end
            if (wr_done) done_seen++;
            prev_done  = ap_done;
            rd_stall_p = rd_cmd_valid && !rd_cmd_ready;
            wr_stall_p = wr_cmd_valid && !wr_cmd_ready;
            rd_p       = {rd_cmd_addr, rd_cmd_len};
            wr_p       = {wr_cmd_addr, wr_cmd_len};
        end
    end

    // B-response responder: one wr_done pulse per accepted write burst.
    initial begin
        wr_done = 1'b0;
        b_sent  = 0;
        forever begin
            @(posedge ACLK); #1;
            if (ARESETn !== 1'b1) begin
                b_sent  = 0;
                wr_done = 1'b0;
            end else if (!wr_done && (b_sent < b_req) && (auto_b || (b_sent < b_grant))) begin
                wr_done = 1'b1;
                b_sent++;
            end else begin
                wr_done = 1'b0;
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- directed sequences --------------------------------
    task automatic start_job(input logic m, input logic c, input logic [63:0] s,
                             input logic [63:0] d, input logic [31:0] w);
        int got;
        @(posedge ACLK); #1;
        mode = m; cbc_mode = c; src_addr = s; dest_addr = d; words_num = w;
        ap_start = 1'b1;
        got = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge ACLK);
            if (ap_ready) begin got = 1; break; end
        end
        chk("ap_ready_seen", 64'(got), 64'd1);
        @(posedge ACLK); #1;
        ap_start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            @(negedge ACLK);
            if (ap_done) break;
        end
        chk(name, 64'(ap_done), 64'd1);
    endtask

    task automatic ack_done();
        @(posedge ACLK); #1; ap_continue = 1'b1;
        @(posedge ACLK); #1; ap_continue = 1'b0;
        @(negedge ACLK);
        chk("ack_idle", 64'(ap_idle), 64'd1);
        chk("ack_done_clear", 64'(ap_done), 64'd0);
    endtask

    initial begin
        int          rc0;
        logic [63:0] a0;
        logic [7:0]  l0;
        ARESETn = 1'b0; ap_start = 1'b0; ap_continue = 1'b0;
        mode = 1'b0; cbc_mode = 1'b0; src_addr = '0; dest_addr = '0; words_num = '0;
        rd_cmd_ready = 1'b1; wr_cmd_ready = 1'b1; auto_b = 1'b1; b_grant = 0;

        repeat (3) @(negedge ACLK);
        chk("rst_idle", 64'(ap_idle), 64'd1);
        chk("rst_ready", 64'(ap_ready), 64'd0);
        chk("rst_done", 64'(ap_done), 64'd0);
        chk("rst_rd_valid", 64'(rd_cmd_valid), 64'd0);
        chk("rst_wr_valid", 64'(wr_cmd_valid), 64'd0);
        chk("rst_cfg", 64'({cfg_mode, cfg_cbc_mode}), 64'd0);
        @(posedge ACLK); #1; ARESETn = 1'b1;

        // Basic 40-word job.
        start_job(1'b1, 1'b0, 64'h1000, 64'h8000, 32'd40);
        wait_done(300, "basic_done");
        chk("basic_ready_once", 64'(ready_cnt), 64'd1);
        chk("basic_rd_count", 64'(rd_log.size()), 64'd3);
        chk("basic_wr_count", 64'(wr_log.size()), 64'd3);
        if (rd_log.size() == 3 && wr_log.size() == 3) begin
            chk("basic_rd0", {rd_log[0].addr[55:0], rd_log[0].len}, {56'h1000, 8'd15});
            chk("basic_rd1", {rd_log[1].addr[55:0], rd_log[1].len}, {56'h1100, 8'd15});
            chk("basic_rd2", {rd_log[2].addr[55:0], rd_log[2].len}, {56'h1200, 8'd7});
            chk("basic_wr2", {wr_log[2].addr[55:0], wr_log[2].len}, {56'h8200, 8'd7});
        end
        chk("basic_acks", 64'(done_seen), 64'd3);
        ack_done();

        // 4 KB page crossing.
        start_job(1'b0, 1'b1, 64'h1FC0, 64'h6000, 32'd8);
        wait_done(200, "cross_done");
        chk("cross_rd_count", 64'(rd_log.size()), 64'd2);
        if (rd_log.size() == 2 && wr_log.size() == 1) begin
            chk("cross_rd0", {rd_log[0].addr[55:0], rd_log[0].len}, {56'h1FC0, 8'd3});
            chk("cross_rd1", {rd_log[1].addr[55:0], rd_log[1].len}, {56'h2000, 8'd3});
            chk("cross_wr0", {wr_log[0].addr[55:0], wr_log[0].len}, {56'h6000, 8'd7});
        end
        ack_done();

        // Zero-length job.
        start_job(1'b1, 1'b1, 64'h7000, 64'h7800, 32'd0);
        wait_done(5, "zero_done");
        chk("zero_rd_none", 64'(rd_hs), 64'd0);
        chk("zero_wr_none", 64'(wr_hs), 64'd0);
        ack_done();

        // Credit stall with write acks withheld.
        auto_b = 1'b0; b_grant = b_sent;
        start_job(1'b0, 1'b0, 64'h40000, 64'h50000, 32'd160);
        repeat (60) @(negedge ACLK);
        chk("stall_rd_count", 64'(rd_hs), 64'd4);
        chk("stall_wr_count", 64'(wr_hs), 64'd4);
        chk("stall_rd_low", 64'(rd_cmd_valid), 64'd0);
        chk("stall_wr_low", 64'(wr_cmd_valid), 64'd0);
        b_grant = b_sent + 1;
        repeat (30) @(negedge ACLK);
        chk("release_rd_count", 64'(rd_hs), 64'd5);
        chk("release_wr_count", 64'(wr_hs), 64'd5);
        auto_b = 1'b1;
        wait_done(600, "stall_done");
        ack_done();

        // Read backpressure, then ap_start held in DONE.
        rd_cmd_ready = 1'b0;
        start_job(1'b1, 1'b0, 64'h3000, 64'h9000, 32'd20);
        for (int i = 0; i < 20; i++) begin
            @(negedge ACLK);
            if (rd_cmd_valid) break;
        end
        chk("bp_valid_up", 64'(rd_cmd_valid), 64'd1);
        a0 = rd_cmd_addr; l0 = rd_cmd_len;
        chk("bp_first_addr", a0, 64'h3000);
        chk("bp_first_len", 64'(l0), 64'd15);
        repeat (10) begin
            @(negedge ACLK);
            chk("bp_stable", {rd_cmd_addr[54:0], rd_cmd_len, rd_cmd_valid}, {a0[54:0], l0, 1'b1});
        end
        @(posedge ACLK); #1; rd_cmd_ready = 1'b1;
        wait_done(300, "bp_done");
        rc0 = ready_cnt;
        @(posedge ACLK); #1; ap_start = 1'b1;
        repeat (10) @(negedge ACLK);
        chk("done_hold", 64'(ap_done), 64'd1);
        chk("done_no_restart", 64'(ready_cnt), 64'(rc0));
        chk("done_no_cmd", 64'({rd_cmd_valid, wr_cmd_valid}), 64'd0);
        @(posedge ACLK); #1; ap_start = 1'b0;
        ack_done();

        // Reset in the middle of ISSUE, then a fresh job.
        auto_b = 1'b0; b_grant = b_sent;
        start_job(1'b0, 1'b0, 64'h10000, 64'h20000, 32'd160);
        for (int i = 0; i < 50; i++) begin
            @(negedge ACLK);
            if (rd_hs >= 2) break;
        end
        chk("mid_two_bursts", 64'(rd_hs >= 2), 64'd1);
        @(negedge ACLK); #2; ARESETn = 1'b0; #1;
        chk("mid_rst_rd_valid", 64'(rd_cmd_valid), 64'd0);
        chk("mid_rst_wr_valid", 64'(wr_cmd_valid), 64'd0);
        chk("mid_rst_idle", 64'(ap_idle), 64'd1);
        repeat (2) @(posedge ACLK);
        #1; ARESETn = 1'b1; auto_b = 1'b1;
        start_job(1'b1, 1'b1, 64'h5000, 64'hA000, 32'd16);
        wait_done(200, "post_rst_done");
        chk("post_rst_rd_count", 64'(rd_log.size()), 64'd1);
        if (rd_log.size() == 1 && wr_log.size() == 1) begin
            chk("post_rst_rd0", {rd_log[0].addr[55:0], rd_log[0].len}, {56'h5000, 8'd15});
            chk("post_rst_wr0", {wr_log[0].addr[55:0], wr_log[0].len}, {56'hA000, 8'd15});
        end
        ack_done();

        repeat (2) @(negedge ACLK);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
